jstk_poll_ctrl: RTL and testbench

JSTK_POLL_CTRL -- requirements
Module: jstk_poll_ctrl

---
 rtl/jstk_poll_ctrl.sv | 157 +++++++++++++++
 tb/tb_jstk_poll_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jstk_poll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jstk_poll_ctrl
// Brief    : Periodic poll sequencer for a joystick SPI block. It launches a
//            request, tracks SS, captures X/Y/buttons and aborts on timeout.
// Revision : 1.0 - initial release
// ============================================================================
module jstk_poll_ctrl #(
    parameter int POLL_DIV = 1000000,
    parameter int TMO      = 500000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic [1:0]  LED_CMD,
    input  logic        SS,
    input  logic [39:0] DOUT,
    output logic        sndRec,
    output logic [7:0]  DIN,
    output logic [9:0]  X,
    output logic [9:0]  Y,
    output logic [2:0]  BTN,
    output logic        VALID,
    output logic        BUSY,
    output logic        TMO_ERR
);

    localparam int c_pw = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int c_tw = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [c_pw-1:0] c_poll_last = c_pw'(POLL_DIV - 1);
    localparam logic [c_tw-1:0] c_tmo_last  = c_tw'(TMO - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_CAPT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_ss_meta;
    logic              r_ss_s;
    logic [c_pw-1:0]   r_poll_cnt;
    logic [c_tw-1:0]   r_tmr;
    logic              w_tick;
    logic              w_tmr_done;
    logic              w_timeout;
    logic              w_dout_unused;

    // Only the position and button bits of the receive word are consumed.
    assign w_dout_unused = ^{DOUT[31:26], DOUT[15:10], DOUT[7:3]};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ss_meta <= 1'b1;
            r_ss_s    <= 1'b1;
        end else begin
            r_ss_meta <= SS;
            r_ss_s    <= r_ss_meta;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_poll_cnt <= '0;
        end else if (!ENABLE || (r_poll_cnt == c_poll_last)) begin
            r_poll_cnt <= '0;
        end else begin
            r_poll_cnt <= r_poll_cnt + 1'b1;
        end
    end

    assign w_tick     = ENABLE && (r_poll_cnt == c_poll_last);
    assign w_tmr_done = (r_tmr == c_tmo_last);

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (!r_ss_s) begin
                    w_next = S_XFER;
                end else if (w_tmr_done) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end
            end
            S_XFER: begin
                if (r_ss_s) begin
                    w_next = S_CAPT;
                end else if (w_tmr_done) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end
            end
            S_CAPT: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Phase timer restarts on any state change and parks at its last count.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_tmr <= '0;
        end else if (w_next != r_state) begin
            r_tmr <= '0;
        end else if (!w_tmr_done) begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sndRec  <= 1'b0;
            DIN     <= 8'h80;
            X       <= '0;
            Y       <= '0;
            BTN     <= '0;
            VALID   <= 1'b0;
            TMO_ERR <= 1'b0;
        end else begin
            sndRec  <= (w_next == S_REQ);
            VALID   <= (r_state == S_CAPT);
            TMO_ERR <= w_timeout;
            if ((r_state == S_IDLE) && (w_next == S_REQ)) begin
                DIN <= {1'b1, 5'b00000, LED_CMD};
            end
            if (r_state == S_CAPT) begin
                X   <= {DOUT[25:24], DOUT[39:32]};
                Y   <= {DOUT[9:8], DOUT[23:16]};
                BTN <= DOUT[2:0];
            end
        end
    end

    assign BUSY = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_jstk_poll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jstk_poll_ctrl
// Brief    : Randomized scoreboard bench for jstk_poll_ctrl with an SS model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jstk_poll_ctrl;

    localparam int PD    = 16;
    localparam int TMO_M = 64;
    localparam int TMO_S = 8;
    localparam int NTXN  = 30;

    logic        CLK;
    logic        RST;
    logic        ENABLE;
    logic [1:0]  LED_CMD;
    logic        SS;
    logic [39:0] DOUT;
    logic        sndRec;
    logic [7:0]  DIN;
    logic [9:0]  X, Y;
    logic [2:0]  BTN;
    logic        VALID, BUSY, TMO_ERR;

    logic        snd2, valid2, busy2, terr2;
    logic [7:0]  din2;
    logic [9:0]  x2, y2;
    logic [2:0]  btn2;

    jstk_poll_ctrl #(.POLL_DIV(PD), .TMO(TMO_M)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .LED_CMD(LED_CMD), .SS(SS),
        .DOUT(DOUT), .sndRec(sndRec), .DIN(DIN), .X(X), .Y(Y), .BTN(BTN),
        .VALID(VALID), .BUSY(BUSY), .TMO_ERR(TMO_ERR)
    );

    jstk_poll_ctrl #(.POLL_DIV(PD), .TMO(TMO_S)) dut_tmo (
        .CLK(CLK), .RST(RST), .ENABLE(1'b1), .LED_CMD(2'b01), .SS(1'b1),
        .DOUT(40'hFF_FF_FF_FF_FF), .sndRec(snd2), .DIN(din2), .X(x2), .Y(y2),
        .BTN(btn2), .VALID(valid2), .BUSY(busy2), .TMO_ERR(terr2)
    );

    typedef struct {
        logic       is_tmo;
        int         cyc;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] btn;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic done2 = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: poll-counter reference, launch timing and event scoreboard.
    int   pcnt = 0;
    logic waiting = 1'b1;
    logic prev_snd = 1'b0;
    logic tick_prev;
    exp_t e;
    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
            tick_prev = RST && ENABLE && (pcnt == PD - 1);
            if (!RST || !ENABLE) pcnt = 0;
            else pcnt = (pcnt == PD - 1) ? 0 : pcnt + 1;
            #1;
            if (!RST) begin
                waiting  = 1'b1;
                prev_snd = 1'b0;
            end else begin
                if (waiting && tick_prev) begin
                    chk("launch_on_tick", {63'd0, sndRec}, 64'd1);
                    waiting = 1'b0;
                end else if (sndRec && !prev_snd) begin
                    chk("unexpected_launch", 64'd1, 64'd0);
                end
                if (sndRec) chk("busy_in_req", {63'd0, BUSY}, 64'd1);
                if (VALID && TMO_ERR) chk("valid_and_tmo", 64'd1, 64'd0);
                if (VALID || TMO_ERR) begin
                    waiting = 1'b1;
                    if (q.size() == 0) begin
                        chk("unexpected_event", {63'd0, VALID}, {63'd0, 1'b0} | 64'd2);
                    end else begin
                        e = q.pop_front();
                        chk("evt_kind",  {63'd0, TMO_ERR}, {63'd0, e.is_tmo});
                        chk("evt_cycle", 64'(cyc), 64'(e.cyc));
                        chk("evt_x",     {54'd0, X},   {54'd0, e.x});
                        chk("evt_y",     {54'd0, Y},   {54'd0, e.y});
                        chk("evt_btn",   {61'd0, BTN}, {61'd0, e.btn});
                    end
                end
                prev_snd = sndRec;
            end
        end
    end

    // Short-timeout instance: SS never answers.
    initial begin
        int n;
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK);
            #1;
            if (RST && snd2) break;
        end
        n = 0;
        while (snd2 && n < 40) begin
            n++;
            @(posedge CLK);
            #1;
        end
        chk("tmo8_sndrec_len", 64'(n), 64'd8);
        chk("tmo8_err",        {63'd0, terr2}, 64'd1);
        chk("tmo8_no_valid",   {63'd0, valid2}, 64'd0);
        chk("tmo8_xyb_kept",   {34'd0, x2, y2, btn2, din2[7]}, 64'd1);
        chk("tmo8_idle",       {63'd0, busy2}, 64'd0);
        @(posedge CLK);
        #1;
        chk("tmo8_err_pulse",  {63'd0, terr2}, 64'd0);
        done2 = 1'b1;
    end

    // Stimulus and SS model.
    initial begin
        int          r, d1, d2, mode, n, m;
        logic        ok;
        logic [39:0] dv;
        logic [1:0]  led_cur, led_l;
        logic [9:0]  lx, ly;
        logic [2:0]  lb;
        exp_t        ex;

        RST = 1'b0; ENABLE = 1'b0; SS = 1'b1; DOUT = '0;
        led_cur = 2'b11; LED_CMD = led_cur;
        lx = '0; ly = '0; lb = '0;
        repeat (3) @(negedge CLK);
        chk("rst_state", {40'd0, sndRec, DIN, X[0], Y[0], BTN, VALID, BUSY, TMO_ERR, X[9:1], 1'b0},
            {40'd0, 1'b0, 8'h80, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0});
        chk("rst_xy", {44'd0, X, Y}, 64'd0);
        RST = 1'b1; ENABLE = 1'b1;

        for (int t = 0; t < NTXN; t++) begin
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge CLK);
                if (sndRec) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                chk("launch_timeout", 64'd0, 64'd1);
                break;
            end
            r = cyc;
            led_l = led_cur;
            chk("din_launch", {56'd0, DIN}, {56'd0, 1'b1, 5'b00000, led_l});

            mode = 0; d1 = $urandom_range(0, 6); d2 = $urandom_range(1, 45);
            dv[31:0] = $urandom; dv[39:32] = 8'($urandom_range(0, 255));
            case (t)
                0: begin d1 = 5; d2 = 20; dv = 40'hA5_02_3C_01_05; end
                1: mode = 1;
                2: begin d1 = 1; d2 = 40; end
                3: begin d1 = 0; d2 = TMO_M; end
                4: d2 = TMO_M + 1;
                5: begin mode = 2; d1 = 3; d2 = 10; end
                6: begin mode = 3; d1 = 2; end
                default: begin
                    m = $urandom_range(0, 9);
                    if (m == 0) mode = 1;
                    else if (m == 1) d2 = TMO_M + 1;
                end
            endcase

            if (mode == 1) begin
                ex = '{is_tmo: 1'b1, cyc: r + TMO_M, x: lx, y: ly, btn: lb};
                q.push_back(ex);
                for (int i = 0; i < TMO_M + 10; i++) begin
                    @(negedge CLK);
                    if (!sndRec) break;
                end
                chk("req_tmo_len", 64'(cyc - r), 64'(TMO_M));
                led_cur = 2'($urandom_range(0, 3)); LED_CMD = led_cur;
            end else begin
                if (mode == 2) ENABLE = 1'b0;
                repeat (d1) @(negedge CLK);
                SS = 1'b0;
                if (mode == 3) begin
                    repeat (6) @(negedge CLK);
                    #2 RST = 1'b0;
                    #1;
                    chk("arst_ctrl", {59'd0, sndRec, VALID, BUSY, TMO_ERR, BTN != 3'd0}, 64'd0);
                    chk("arst_din",  {56'd0, DIN}, 64'h80);
                    chk("arst_xy",   {44'd0, X, Y}, 64'd0);
                    lx = '0; ly = '0; lb = '0;
                    @(negedge CLK);
                    SS = 1'b1;
                    repeat (2) @(negedge CLK);
                    RST = 1'b1;
                end else begin
                    if (d2 <= TMO_M) begin
                        lx = {dv[25:24], dv[39:32]};
                        ly = {dv[9:8], dv[23:16]};
                        lb = dv[2:0];
                        ex = '{is_tmo: 1'b0, cyc: r + d1 + d2 + 4, x: lx, y: ly, btn: lb};
                    end else begin
                        ex = '{is_tmo: 1'b1, cyc: r + d1 + 3 + TMO_M, x: lx, y: ly, btn: lb};
                    end
                    q.push_back(ex);
                    repeat (d2) @(negedge CLK);
                    DOUT = dv;
                    SS = 1'b1;
                    led_cur = (t == 0) ? 2'b00 : 2'($urandom_range(0, 3));
                    LED_CMD = led_cur;
                    repeat ((d2 <= TMO_M) ? 4 : 2) begin
                        @(negedge CLK);
                        chk("din_hold", {56'd0, DIN}, {56'd0, 1'b1, 5'b00000, led_l});
                    end
                    if (t == 0) begin
                        chk("x_fixed",   {54'd0, X},   64'h2A5);
                        chk("y_fixed",   {54'd0, Y},   64'h13C);
                        chk("btn_fixed", {61'd0, BTN}, 64'h5);
                    end
                    if (mode == 2) begin
                        n = 0;
                        repeat (3 * PD) begin
                            @(negedge CLK);
                            if (sndRec) n++;
                        end
                        chk("no_poll_disabled", 64'(n), 64'd0);
                        ENABLE = 1'b1;
                    end
                end
            end
        end

        repeat (20) @(negedge CLK);
        for (int i = 0; i < 400 && !done2; i++) @(negedge CLK);
        chk("tmo8_done", {63'd0, done2}, 64'd1);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
